// File: rtl/gemm_dot_sequencer.sv
// Row-at-a-time sequencer for the 32-lane dot-product engine: issues operand chunks, accumulates dot_sum, emits row results.
// Optional build macro GEMM_SEQ_SAT_EN: saturating accumulator plus a res_ovf flag.
module gemm_dot_sequencer #(
    parameter int DOT_LAT = 1,
    parameter int ACC_W   = 32,
    parameter int ROW_W   = 8,
    parameter int CHK_W   = 8,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ROW_W-1:0]  cmd_rows,
    input  logic [CHK_W-1:0]  cmd_chunks,
    output logic              op_valid,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [17:0]       dot_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [ROW_W-1:0]  res_row,
`ifdef GEMM_SEQ_SAT_EN
    output logic              res_ovf,
`endif
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ROW_W-1:0]    r_rows;
    logic [CHK_W-1:0]    r_chunks;
    logic [ROW_W-1:0]    r_row;
    logic [CHK_W-1:0]    r_chunk;
    logic [ADDR_W-1:0]   r_a_addr;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic                r_done;
    logic [DOT_LAT-1:0]  r_pipe;
    logic [DOT_LAT-1:0]  w_pipe_nxt;
    logic                w_tap;
    logic                w_cmd_fire;
    logic                w_cmd_zero;
    logic                w_res_fire;
    logic                w_last_chunk;
    logic                w_last_row;

    // Valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
    // while valid is high and ready low, the producer holds valid and its payload unchanged.
    assign w_cmd_fire   = cmd_valid & cmd_ready;
    assign w_cmd_zero   = (cmd_rows == '0) | (cmd_chunks == '0);
    assign w_res_fire   = res_valid & res_ready;
    assign w_last_chunk = (r_chunk == r_chunks - CHK_W'(1));
    assign w_last_row   = (r_row == r_rows - ROW_W'(1));
    assign w_tap        = r_pipe[DOT_LAT-1];

    // Shift register of issued op_valid; its tap marks the cycle dot_sum belongs to an issue.
    generate
        if (DOT_LAT == 1) begin : g_pipe_one
            assign w_pipe_nxt = op_valid;
        end else begin : g_pipe_many
            assign w_pipe_nxt = {r_pipe[DOT_LAT-2:0], op_valid};
        end
    endgenerate

`ifdef GEMM_SEQ_SAT_EN
    logic [ACC_W:0] w_acc_sum;
    logic           r_ovf;
    assign w_acc_sum = {1'b0, r_acc} + {{(ACC_W + 1 - 18){1'b0}}, dot_sum};
    assign w_acc_nxt = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
    assign res_ovf   = r_ovf;
`else
    assign w_acc_nxt = r_acc + ACC_W'(dot_sum);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN leaves once the shifted pipeline would be empty, i.e. the final capture is this cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_fire && !w_cmd_zero) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_last_chunk) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pipe_nxt == '0) w_state_nxt = S_OUT;
            S_OUT:   if (w_res_fire) w_state_nxt = w_last_row ? S_IDLE : S_ISSUE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows   <= '0;
            r_chunks <= '0;
            r_row    <= '0;
            r_chunk  <= '0;
            r_a_addr <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_pipe   <= '0;
`ifdef GEMM_SEQ_SAT_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_pipe <= w_pipe_nxt;
            r_done <= 1'b0;
            if (w_tap) begin
                r_acc <= w_acc_nxt;
`ifdef GEMM_SEQ_SAT_EN
                if (w_acc_sum[ACC_W]) r_ovf <= 1'b1;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_rows   <= cmd_rows;
                        r_chunks <= cmd_chunks;
                        if (w_cmd_zero) begin
                            r_done <= 1'b1;
                        end else begin
                            r_row    <= '0;
                            r_chunk  <= '0;
                            r_a_addr <= '0;
                            r_acc    <= '0;
`ifdef GEMM_SEQ_SAT_EN
                            r_ovf    <= 1'b0;
`endif
                        end
                    end
                end
                S_ISSUE: begin
                    r_a_addr <= r_a_addr + ADDR_W'(1);
                    r_chunk  <= w_last_chunk ? '0 : r_chunk + CHK_W'(1);
                end
                S_OUT: begin
                    if (w_res_fire) begin
                        if (w_last_row) begin
                            r_done <= 1'b1;
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                            r_acc <= '0;
`ifdef GEMM_SEQ_SAT_EN
                            r_ovf <= 1'b0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign op_valid  = (r_state == S_ISSUE);
    assign res_valid = (r_state == S_OUT);
    assign a_addr    = r_a_addr;
    assign b_addr    = ADDR_W'(r_chunk);
    assign res_data  = r_acc;
    assign res_row   = r_row;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gemm_dot_sequencer.sv
// Bench for gemm_dot_sequencer: two instances (DOT_LAT=1/ACC_W=32 and DOT_LAT=4/ACC_W=20) against an arithmetic row-sum model.
module tb_gemm_dot_sequencer;
  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cv0, cv1, rr0, rr1;
  logic [7:0]  rows0, rows1, chk0, chk1;
  logic [17:0] ds0, ds1;
  logic        cr0, cr1, ov0, ov1, rv0, rv1, busy0, busy1, done0, done1;
  logic [15:0] aa0, aa1, ba0, ba1;
  logic [31:0] rd0;
  logic [19:0] rd1;
  logic [7:0]  row0, row1;
  logic [1:0]  st0, st1;
`ifdef GEMM_SEQ_SAT_EN
  logic        ovf0, ovf1;
`endif

  gemm_dot_sequencer #(.DOT_LAT(LAT0), .ACC_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv0), .cmd_ready(cr0), .cmd_rows(rows0), .cmd_chunks(chk0),
    .op_valid(ov0), .a_addr(aa0), .b_addr(ba0), .dot_sum(ds0), .res_valid(rv0), .res_ready(rr0),
    .res_data(rd0), .res_row(row0),
`ifdef GEMM_SEQ_SAT_EN
    .res_ovf(ovf0),
`endif
    .busy(busy0), .done(done0), .dbg_state(st0)
  );

  gemm_dot_sequencer #(.DOT_LAT(LAT1), .ACC_W(20)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(cr1), .cmd_rows(rows1), .cmd_chunks(chk1),
    .op_valid(ov1), .a_addr(aa1), .b_addr(ba1), .dot_sum(ds1), .res_valid(rv1), .res_ready(rr1),
    .res_data(rd1), .res_row(row1),
`ifdef GEMM_SEQ_SAT_EN
    .res_ovf(ovf1),
`endif
    .busy(busy1), .done(done1), .dbg_state(st1)
  );

  // Per-instance views of the outputs so tasks can select an instance by index.
  logic [31:0] rd_v [2];
  logic [15:0] aa_v [2];
  logic [15:0] ba_v [2];
  logic [7:0]  row_v [2];
  logic        ov_v [2];
  logic        rv_v [2];
  logic        cr_v [2];
  logic        busy_v [2];
  logic        done_v [2];
  logic        ovf_v [2];
  always_comb begin
    rd_v[0] = rd0;      rd_v[1] = 32'(rd1);
    aa_v[0] = aa0;      aa_v[1] = aa1;
    ba_v[0] = ba0;      ba_v[1] = ba1;
    row_v[0] = row0;    row_v[1] = row1;
    ov_v[0] = ov0;      ov_v[1] = ov1;
    rv_v[0] = rv0;      rv_v[1] = rv1;
    cr_v[0] = cr0;      cr_v[1] = cr1;
    busy_v[0] = busy0;  busy_v[1] = busy1;
    done_v[0] = done0;  done_v[1] = done1;
`ifdef GEMM_SEQ_SAT_EN
    ovf_v[0] = ovf0;    ovf_v[1] = ovf1;
`else
    ovf_v[0] = 1'b0;    ovf_v[1] = 1'b0;
`endif
  end

  // Engine stand-in: the value for an issued chunk is an affine function of its activation address.
  int unsigned mul_v [2];
  int unsigned add_v [2];

  function automatic logic [17:0] dot_val(int s, logic [15:0] addr);
    return 18'(mul_v[s] * 32'(addr) + add_v[s]);
  endfunction

  logic [17:0] pend [2];
  logic [17:0] line0;
  logic [17:0] line1 [LAT1];

  always @(negedge clk) begin
    pend[0] = ov0 ? dot_val(0, aa0) : 18'h0;
    pend[1] = ov1 ? dot_val(1, aa1) : 18'h0;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      line0 = 18'h0;
      for (int i = 0; i < LAT1; i++) line1[i] = 18'h0;
    end else begin
      line0 = pend[0];
      for (int i = LAT1 - 1; i > 0; i--) line1[i] = line1[i-1];
      line1[0] = pend[1];
    end
    ds0 = line0;
    ds1 = line1[LAT1-1];
  end

  // Reference model: a row result is the plain sum of its chunk values, reduced to the accumulator width.
  function automatic longint unsigned row_total(int s, int r, int chunks);
    longint unsigned t = 0;
    for (int c = 0; c < chunks; c++) t += 64'(dot_val(s, 16'(r * chunks + c)));
    return t;
  endfunction

  function automatic longint unsigned acc_max(int s);
    return (s == 1) ? 64'h000F_FFFF : 64'hFFFF_FFFF;
  endfunction

  function automatic logic [63:0] exp_data(int s, longint unsigned total);
`ifdef GEMM_SEQ_SAT_EN
    return (total > acc_max(s)) ? acc_max(s) : total;
`else
    return total & acc_max(s);
`endif
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(int s, logic v, int rows, int chunks);
    if (s == 0) begin
      cv0 = v; rows0 = 8'(rows); chk0 = 8'(chunks);
    end else begin
      cv1 = v; rows1 = 8'(rows); chk1 = 8'(chunks);
    end
  endtask

  task automatic set_rr(int s, logic v);
    if (s == 0) rr0 = v;
    else rr1 = v;
  endtask

  // Issues one command and follows it to completion, checking every cycle at the falling edge.
  task automatic run_cmd(int s, int rows, int chunks, int stall_row, int stall_n, bit poke);
    int lat = (s == 1) ? LAT1 : LAT0;
    int exp_row = 0, exp_chunk = 0, exp_addr = 0, held = 0, cyc = 0, first_issue = -1;
    bit done_due, hs_next = 0, seen_rv = 0, finished = 0;
    longint unsigned total;
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cr_v[s]), 64'd1);
    set_cmd(s, 1'b1, rows, chunks);
    set_rr(s, 1'b1);
    @(negedge clk);
    set_cmd(s, 1'b0, 0, 0);
    done_due = (rows == 0) || (chunks == 0);
    while (!finished && cyc < 400) begin
      if (hs_next) begin
        exp_row++; seen_rv = 0; held = 0; first_issue = -1; hs_next = 0;
      end
      chk("done", 64'(done_v[s]), 64'(done_due));
      if (done_due) begin
        chk("done_no_op", 64'(ov_v[s]), 64'd0);
        chk("done_no_res", 64'(rv_v[s]), 64'd0);
        finished = 1;
      end else begin
        if (ov_v[s]) begin
          if (first_issue < 0) first_issue = cyc;
          chk("a_addr", 64'(aa_v[s]), 64'(exp_addr & 16'hFFFF));
          chk("b_addr", 64'(ba_v[s]), 64'(exp_chunk));
          exp_addr++;
          exp_chunk = (exp_chunk == chunks - 1) ? 0 : exp_chunk + 1;
        end
        if (rv_v[s]) begin
          total = row_total(s, exp_row, chunks);
          if (!seen_rv) chk("row_latency", 64'(cyc - first_issue), 64'(chunks + lat));
          seen_rv = 1;
          chk("res_row", 64'(row_v[s]), 64'(exp_row));
          chk("res_data", rd_v[s], exp_data(s, total));
`ifdef GEMM_SEQ_SAT_EN
          chk("res_ovf", 64'(ovf_v[s]), 64'(total > acc_max(s)));
`endif
          chk("no_op_in_out", 64'(ov_v[s]), 64'd0);
          if (exp_row == stall_row && held < stall_n) begin
            set_rr(s, 1'b0); held++;
          end else begin
            set_rr(s, 1'b1); hs_next = 1;
          end
        end
        done_due = hs_next && (exp_row == rows - 1);
        if (poke && cyc == 2) begin
          chk("poke_busy", 64'(busy_v[s]), 64'd1);
          set_cmd(s, 1'b1, 7, 1);
        end else if (poke && cyc == 3) begin
          set_cmd(s, 1'b0, 0, 0);
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("finished_in_budget", 64'(finished), 64'd1);
    set_rr(s, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", 64'(done_v[s]), 64'd0);
    chk("cmd_ready_back", 64'(cr_v[s]), 64'd1);
    chk("idle_no_op", 64'(ov_v[s]), 64'd0);
    chk("not_busy", 64'(busy_v[s]), 64'd0);
  endtask

  initial begin
    int rows, chunks, s, waited;
    rst_n = 1'b0;
    set_cmd(0, 1'b0, 0, 0); set_cmd(1, 1'b0, 0, 0);
    rr0 = 1'b1; rr1 = 1'b1;
    mul_v[0] = 1; add_v[0] = 1; mul_v[1] = 0; add_v[1] = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_op_valid", 64'(ov_v[k]), 64'd0);
      chk("rst_a_addr", 64'(aa_v[k]), 64'd0);
      chk("rst_b_addr", 64'(ba_v[k]), 64'd0);
      chk("rst_res_valid", 64'(rv_v[k]), 64'd0);
      chk("rst_res_data", rd_v[k], 64'd0);
      chk("rst_res_row", 64'(row_v[k]), 64'd0);
      chk("rst_busy", 64'(busy_v[k]), 64'd0);
      chk("rst_done", 64'(done_v[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst0", 64'(cr0), 64'd1);
    chk("cmd_ready_after_rst1", 64'(cr1), 64'd1);

    // Basic: dot_sum = a_addr + 1 gives rows 6 and 15.
    chk("model_row0", exp_data(0, row_total(0, 0, 3)), 64'd6);
    chk("model_row1", exp_data(0, row_total(0, 1, 3)), 64'd15);
    run_cmd(0, 2, 3, -1, 0, 1'b0);
    // Backpressure on row 0 for five cycles.
    run_cmd(0, 2, 3, 0, 5, 1'b0);
    // Latency with the deep engine.
    mul_v[1] = 0; add_v[1] = 100;
    run_cmd(1, 1, 1, -1, 0, 1'b0);
    // Zero-sized commands.
    run_cmd(0, 0, 5, -1, 0, 1'b0);
    run_cmd(1, 3, 0, -1, 0, 1'b0);
    // Overflow on the 20-bit accumulator.
    add_v[1] = 32'h3FFFF;
`ifdef GEMM_SEQ_SAT_EN
    chk("model_ovf", exp_data(1, row_total(1, 0, 8)), 64'hFFFFF);
`else
    chk("model_ovf", exp_data(1, row_total(1, 0, 8)), 64'hFFFF8);
`endif
    run_cmd(1, 1, 8, -1, 0, 1'b0);
    // A command offered while busy must be ignored.
    mul_v[0] = 3; add_v[0] = 5;
    run_cmd(0, 2, 2, -1, 0, 1'b1);

    for (int k = 0; k < 10; k++) begin
      s = k % 2;
      mul_v[s] = $urandom;
      add_v[s] = $urandom;
      rows = $urandom_range(1, 4);
      chunks = $urandom_range(1, 6);
      run_cmd(s, rows, chunks, $urandom_range(0, 3), $urandom_range(0, 3), 1'(k % 3 == 0));
    end

    // Reset while issuing chunk 2, then a fresh command.
    mul_v[0] = 0; add_v[0] = 7;
    @(negedge clk);
    set_cmd(0, 1'b1, 1, 4);
    @(negedge clk);
    set_cmd(0, 1'b0, 0, 0);
    waited = 0;
    while (!(ov0 && ba0 == 16'd2) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("reached_chunk2", 64'(ov0 && ba0 == 16'd2), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_op_valid", 64'(ov0), 64'd0);
    chk("abort_a_addr", 64'(aa0), 64'd0);
    chk("abort_b_addr", 64'(ba0), 64'd0);
    chk("abort_res_valid", 64'(rv0), 64'd0);
    chk("abort_res_data", 64'(rd0), 64'd0);
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", 64'(done0), 64'd0);
    chk("model_after_abort", exp_data(0, row_total(0, 0, 2)), 64'd14);
    run_cmd(0, 1, 2, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
